// File: rtl/dm_stage.sv
// dm_stage: memory-stage data RAM for the five-stage MIPS pipeline.
// Word-organised, little-endian storage with word/half/byte stores,
// sign/zero-extended loads, alignment/range checking, and a registered
// commit record of every store that actually wrote the array.
module dm_stage #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_we,
   input  logic        mem_re,
   input  logic [1:0]  store_size,
   input  logic [2:0]  load_size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic        wr_valid,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic [31:0] wr_pc
);

   localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-3:0] word_idx;
   logic [31:0]           cur_word;
   logic [31:0]           merged;
   logic [15:0]           sel_half;
   logic [7:0]            sel_byte;
   logic                  oor;
   logic                  misaligned_store;
   logic                  misaligned_load;
   logic                  do_store;

   assign word_idx = addr[ADDR_WIDTH-1:2];
   assign cur_word = mem[word_idx];
   assign oor      = |addr[31:ADDR_WIDTH];
   assign sel_half = addr[1] ? cur_word[31:16] : cur_word[15:0];
   assign sel_byte = cur_word[{addr[1:0], 3'b000} +: 8];

   // Alignment rules: words need addr[1:0]=0, halves need addr[0]=0, bytes always fine.
   always_comb begin
      misaligned_store = 1'b0;
      misaligned_load  = 1'b0;
      case (store_size)
         2'b00:   misaligned_store = |addr[1:0];
         2'b01:   misaligned_store = addr[0];
         default: misaligned_store = 1'b0;
      endcase
      case (load_size)
         3'b001, 3'b010: misaligned_load = addr[0];
         3'b011, 3'b100: misaligned_load = 1'b0;
         default:        misaligned_load = |addr[1:0];
      endcase
   end

   assign addr_err = (mem_we & (misaligned_store | oor)) |
                     (mem_re & (misaligned_load | oor));

   // Reserved store_size is a silent no-op rather than an error.
   assign do_store = mem_we & ~addr_err & (store_size != 2'b11);

   // Merge the store data into the current word; untouched lanes keep their old bytes.
   always_comb begin
      merged = cur_word;
      case (store_size)
         2'b00: merged = wdata;
         2'b01: begin
            if (addr[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
         end
         2'b10: merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
         default: merged = cur_word;
      endcase
   end

   // Extract and extend the load result; the read is of pre-store contents.
   always_comb begin
      rdata = '0;
      if (mem_re && !addr_err) begin
         case (load_size)
            3'b001:  rdata = {{16{sel_half[15]}}, sel_half};
            3'b010:  rdata = {16'h0000, sel_half};
            3'b011:  rdata = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  rdata = {24'h000000, sel_byte};
            default: rdata = cur_word;
         endcase
      end
   end

   // Memory array: reset clears every word and wins over a simultaneous store.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_store) begin
         mem[word_idx] <= merged;
      end
   end

   // Commit record: pulses for each performed store and holds its fields otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_pc    <= '0;
      end else begin
         wr_valid <= do_store;
         if (do_store) begin
            wr_addr <= {addr[31:2], 2'b00};
            wr_data <= merged;
            wr_pc   <= pc;
         end
      end
   end

endmodule

// File: tb/tb_dm_stage.sv
// tb_dm_stage: directed and randomized checks of dm_stage against a
// byte-addressed reference model of the data memory.
module tb_dm_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_we;
   logic        mem_re;
   logic [1:0]  store_size;
   logic [2:0]  load_size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] pc;
   logic [31:0] rdata;
   logic        addr_err;
   logic        wr_valid;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [31:0] wr_pc;

   // Reference model state: a flat byte array plus the expected commit record.
   logic [7:0]  ref_mem [4096];
   logic        exp_valid;
   logic [31:0] exp_waddr;
   logic [31:0] exp_wdata;
   logic [31:0] exp_wpc;

   int n_checks = 0;
   int n_fail   = 0;

   dm_stage #(.ADDR_WIDTH(12)) dut (
      .clk(clk),
      .reset(reset),
      .mem_we(mem_we),
      .mem_re(mem_re),
      .store_size(store_size),
      .load_size(load_size),
      .addr(addr),
      .wdata(wdata),
      .pc(pc),
      .rdata(rdata),
      .addr_err(addr_err),
      .wr_valid(wr_valid),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_pc(wr_pc)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   function automatic logic model_err(input logic we, input logic re,
                                      input logic [1:0] ss, input logic [2:0] ls,
                                      input logic [31:0] a);
      logic out_of_range;
      logic bad_store;
      logic bad_load;
      out_of_range = (a >= 32'd4096);
      bad_store = ((ss == 2'd0) && (a % 4 != 0)) || ((ss == 2'd1) && (a % 2 != 0));
      if (ls == 3'd1 || ls == 3'd2)      bad_load = (a % 2 != 0);
      else if (ls == 3'd3 || ls == 3'd4) bad_load = 1'b0;
      else                               bad_load = (a % 4 != 0);
      return (we && (bad_store || out_of_range)) || (re && (bad_load || out_of_range));
   endfunction

   function automatic logic [31:0] model_word(input int ia);
      int base;
      base = ia - (ia % 4);
      return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] ls, input logic [31:0] a);
      int          ia;
      logic [15:0] h;
      logic [7:0]  b;
      ia = int'(a[11:0]);
      b  = ref_mem[ia];
      h  = (ia % 2 == 0) ? {ref_mem[ia+1], ref_mem[ia]} : 16'h0;
      case (ls)
         3'd1:    return {{16{h[15]}}, h};
         3'd2:    return {16'h0, h};
         3'd3:    return {{24{b[7]}}, b};
         3'd4:    return {24'h0, b};
         default: return model_word(ia);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic we, input logic re,
                                input logic [1:0] ss, input logic [2:0] ls,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] p);
      @(negedge clk);
      reset      = rst;
      mem_we     = we;
      mem_re     = re;
      store_size = ss;
      load_size  = ls;
      addr       = a;
      wdata      = d;
      pc         = p;
      #2;
   endtask

   // Check the combinational outputs, advance the model and the DUT one edge, check the record.
   task automatic checkOutput(input string tag);
      logic        err;
      logic [31:0] exp_r;
      int          ia;
      int          nbytes;
      err   = model_err(mem_we, mem_re, store_size, load_size, addr);
      exp_r = (mem_re && !err) ? model_load(load_size, addr) : 32'h0;
      check({tag, " addr_err"}, {31'h0, addr_err}, {31'h0, err});
      check({tag, " rdata"}, rdata, exp_r);
      if (reset) begin
         for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
         exp_valid = 1'b0;
         exp_waddr = 32'h0;
         exp_wdata = 32'h0;
         exp_wpc   = 32'h0;
      end else if (mem_we && !err && store_size != 2'd3) begin
         ia     = int'(addr[11:0]);
         nbytes = (store_size == 2'd0) ? 4 : (store_size == 2'd1) ? 2 : 1;
         for (int i = 0; i < nbytes; i++) ref_mem[ia+i] = wdata[8*i +: 8];
         exp_valid = 1'b1;
         exp_waddr = addr - (addr % 4);
         exp_wdata = model_word(ia);
         exp_wpc   = pc;
      end else begin
         exp_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check({tag, " wr_valid"}, {31'h0, wr_valid}, {31'h0, exp_valid});
      check({tag, " wr_addr"}, wr_addr, exp_waddr);
      check({tag, " wr_data"}, wr_data, exp_wdata);
      check({tag, " wr_pc"}, wr_pc, exp_wpc);
   endtask

   initial begin
      logic        r_rst;
      logic        r_we;
      logic        r_re;
      logic [31:0] r_addr;

      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
      exp_valid = 1'b0;
      exp_waddr = 32'h0;
      exp_wdata = 32'h0;
      exp_wpc   = 32'h0;

      // Reset state.
      applyStimulus(1, 0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
      checkOutput("reset");
      check("reset wr_valid const", {31'h0, wr_valid}, 32'h0);

      // Word store and load.
      applyStimulus(0, 1, 0, 2'd0, 3'd0, 32'h10, 32'h12345678, 32'h400);
      checkOutput("sw 0x10");
      check("sw 0x10 wr_data const", wr_data, 32'h12345678);
      check("sw 0x10 wr_addr const", wr_addr, 32'h10);
      applyStimulus(0, 0, 1, 2'd0, 3'd0, 32'h10, 32'h0, 32'h404);
      check("lw 0x10 const", rdata, 32'h12345678);
      checkOutput("lw 0x10");

      // Byte merge and extension.
      applyStimulus(0, 1, 0, 2'd2, 3'd0, 32'h11, 32'hFFFFFFAB, 32'h408);
      checkOutput("sb 0x11");
      check("sb 0x11 wr_data const", wr_data, 32'h1234AB78);
      applyStimulus(0, 0, 1, 2'd0, 3'd3, 32'h11, 32'h0, 32'h40C);
      check("lb 0x11 const", rdata, 32'hFFFFFFAB);
      checkOutput("lb 0x11");
      applyStimulus(0, 0, 1, 2'd0, 3'd4, 32'h11, 32'h0, 32'h410);
      check("lbu 0x11 const", rdata, 32'h000000AB);
      checkOutput("lbu 0x11");
      applyStimulus(0, 0, 1, 2'd0, 3'd1, 32'h12, 32'h0, 32'h414);
      check("lh 0x12 const", rdata, 32'h00001234);
      checkOutput("lh 0x12");

      // Half store over the merged word.
      applyStimulus(0, 1, 0, 2'd1, 3'd0, 32'h12, 32'h00008001, 32'h418);
      checkOutput("sh 0x12");
      check("sh 0x12 wr_data const", wr_data, 32'h8001AB78);
      applyStimulus(0, 0, 1, 2'd0, 3'd1, 32'h12, 32'h0, 32'h41C);
      check("lh 0x12 after sh const", rdata, 32'hFFFF8001);
      checkOutput("lh 0x12 after sh");
      applyStimulus(0, 0, 1, 2'd0, 3'd2, 32'h12, 32'h0, 32'h420);
      check("lhu 0x12 const", rdata, 32'h00008001);
      checkOutput("lhu 0x12");

      // Misaligned and out-of-range accesses.
      applyStimulus(0, 1, 0, 2'd1, 3'd0, 32'h13, 32'h5555, 32'h424);
      check("sh 0x13 err const", {31'h0, addr_err}, 32'h1);
      checkOutput("sh 0x13");
      check("sh 0x13 no commit const", {31'h0, wr_valid}, 32'h0);
      applyStimulus(0, 0, 1, 2'd0, 3'd0, 32'h1000, 32'h0, 32'h428);
      check("lw 0x1000 err const", {31'h0, addr_err}, 32'h1);
      check("lw 0x1000 rdata const", rdata, 32'h0);
      checkOutput("lw 0x1000");
      applyStimulus(0, 1, 0, 2'd0, 3'd0, 32'h1000, 32'hCAFEF00D, 32'h42C);
      checkOutput("sw 0x1000");
      applyStimulus(0, 0, 1, 2'd0, 3'd0, 32'h0, 32'h0, 32'h430);
      check("lw 0x0 no alias const", rdata, 32'h0);
      checkOutput("lw 0x0 no alias");

      // Same-cycle store and load see old data, next cycle sees new.
      applyStimulus(0, 1, 1, 2'd0, 3'd0, 32'h20, 32'hDEADBEEF, 32'h434);
      check("sw/lw 0x20 old const", rdata, 32'h0);
      checkOutput("sw/lw 0x20");
      applyStimulus(0, 0, 1, 2'd0, 3'd0, 32'h20, 32'h0, 32'h438);
      check("lw 0x20 new const", rdata, 32'hDEADBEEF);
      checkOutput("lw 0x20 new");

      // Back-to-back byte stores into the same word.
      applyStimulus(0, 1, 0, 2'd2, 3'd0, 32'h24, 32'h11, 32'h43C);
      checkOutput("sb 0x24");
      applyStimulus(0, 1, 0, 2'd2, 3'd0, 32'h25, 32'h22, 32'h440);
      checkOutput("sb 0x25");
      check("b2b merge const", wr_data, 32'h00002211);

      // Reserved store size performs no write.
      applyStimulus(0, 1, 0, 2'd3, 3'd0, 32'h28, 32'hFFFFFFFF, 32'h444);
      checkOutput("reserved store");
      check("reserved no commit const", {31'h0, wr_valid}, 32'h0);

      // Reset with a simultaneous store clears everything.
      applyStimulus(1, 1, 0, 2'd0, 3'd0, 32'h30, 32'h77777777, 32'h448);
      checkOutput("reset with sw");
      check("post-reset wr_pc const", wr_pc, 32'h0);
      applyStimulus(0, 0, 1, 2'd0, 3'd0, 32'h10, 32'h0, 32'h44C);
      checkOutput("post-reset lw 0x10");
      applyStimulus(0, 0, 1, 2'd0, 3'd0, 32'h30, 32'h0, 32'h450);
      check("post-reset lw 0x30 const", rdata, 32'h0);
      checkOutput("post-reset lw 0x30");

      // Randomized traffic concentrated on a small window to force overlaps.
      for (int n = 0; n < 400; n++) begin
         r_rst = ($urandom_range(0, 99) < 2);
         r_we  = 1'($urandom_range(0, 1));
         r_re  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) r_addr = 32'h1000 + $urandom_range(0, 15);
         else if ($urandom_range(0, 29) == 0) r_addr = $urandom;
         else r_addr = $urandom_range(0, 63);
         applyStimulus(r_rst, r_we, r_re, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                       r_addr, $urandom, $urandom);
         checkOutput("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_stage.md
# dm_stage

Memory-stage data memory for the five-stage MIPS pipeline, sitting directly upstream of the M/W pipeline register and producing the value it latches as `DMout_M`. Holds a word-organised, little-endian data RAM with word/half/byte stores and sign/zero-extended loads. Detects misaligned and out-of-range accesses, and publishes a registered commit record of every completed store for the testbench and trace logging.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address bits decoded; memory is 2^(ADDR_WIDTH-2) 32-bit words (default 1024 words = 4 KiB)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- mem_we  in  1  store in M this cycle
- mem_re  in  1  load in M this cycle
- store_size  in  2  00 word, 01 half, 10 byte, 11 reserved (no write)
- load_size  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others treated as lw
- addr  in  32  byte address (ALU result in M)
- wdata  in  32  store data, already forwarded
- pc  in  32  PC of instruction in M
- rdata  out  32  extended load result; combinational
- addr_err  out  1  active access is misaligned or out of range; combinational
- wr_valid  out  1  a store committed at the last edge; registered
- wr_addr  out  32  word-aligned address of the committed store; registered
- wr_data  out  32  full merged word after the committed store; registered
- wr_pc  out  32  PC of the committed store; registered

## Operation
- Word index = addr[ADDR_WIDTH-1:2]. An address is out of range when any of addr[31:ADDR_WIDTH] is nonzero.
- Misaligned: word access with addr[1:0]≠0; half access with addr[0]≠0; byte accesses are never misaligned.
- addr_err = (mem_we & (misaligned_store | oor)) | (mem_re & (misaligned_load | oor)). Reserved store_size is not an error; it performs no write.
- Store on rising edge when mem_we & !addr_err & !reset & store_size≠11:
  - word: replace the whole word.
  - half: write wdata[15:0] to bytes {1,0} if addr[1]=0, else to bytes {3,2}.
  - byte: write wdata[7:0] to byte lane addr[1:0].
  - Unwritten lanes are preserved.
- Load (combinational): the addressed word is read asynchronously.
  - lh/lhu select the half by addr[1]; lb/lbu select the byte by addr[1:0].
  - Signed variants sign-extend; unsigned variants zero-extend.
  - rdata = 0 when addr_err=1 or mem_re=0.
- Commit record: at each edge, wr_valid <= store-performed condition. When a store is performed, wr_addr/wr_data/wr_pc are loaded with {addr[31:2],2'b00}, the merged word, and pc. Otherwise they hold their previous values.
- If both mem_we and mem_re are asserted, the store and the load are evaluated independently. The load sees pre-store contents.

## Timing
- Reset (sync): at the edge with reset=1, every memory word is cleared to 0, wr_valid=0, and wr_addr=wr_data=wr_pc=0. Reset overrides any simultaneous store.
- rdata and addr_err have zero-cycle latency. They are stable before the edge that loads the M/W register.
- Store latency is one edge: data written at edge N is visible on rdata in the cycle after edge N. Reading the same address in the store's own cycle returns the old data (no internal bypass).
- The commit record appears in the cycle after the store's edge and lasts exactly one cycle unless the next instruction also stores.
- Back-to-back stores to the same word in consecutive cycles merge correctly. The second store's merge uses the contents written by the first.
- Reset asserted mid-stream discards the in-flight store. Memory contents after the reset edge are all zero.

## Test plan
- Word store/load: sw 0x12345678 @0x10, next cycle lw @0x10 -> rdata=0x12345678. The store's commit cycle shows wr_valid=1, wr_addr=0x10, wr_data=0x12345678.
- Byte merge and extension: after the above, sb 0xAB @0x11 -> wr_data=0x1234AB78. Then lb @0x11 -> 0xFFFFFFAB; lbu @0x11 -> 0x000000AB; lh @0x12 -> 0x00001234.
- Half store: sh 0x8001 @0x12 over 0x1234AB78 -> word becomes 0x8001AB78. lh @0x12 -> 0xFFFF8001; lhu @0x12 -> 0x00008001.
- Misaligned/out-of-range: sh @0x13 -> addr_err=1, no write, wr_valid=0 next cycle. lw @0x1000 (ADDR_WIDTH=12) -> addr_err=1, rdata=0. A store to 0x1000 does not alias word 0.
- Same-cycle read/write: sw 0xDEADBEEF @0x20 with mem_re, lw @0x20 in the same cycle -> rdata shows the old value 0. The following cycle -> 0xDEADBEEF.
- Reset: fill several words, then assert reset together with sw @0x30 -> after the edge, all words read 0, wr_valid=0, and wr_addr/wr_data/wr_pc=0.
